// File: rtl/padctrl_reg_pkg.sv
// Pad control constants: pad counts, attribute width and bit positions.
// Shared by the pad conditioning stage, its interface and the input filter.
package padctrl_reg_pkg;

  localparam int NMioPads    = 12;
  localparam int NDioPads    = 8;
  localparam int AttrDw      = 8;

  localparam int AttrInvBit  = 0;
  localparam int AttrOdBit   = 1;
  localparam int AttrFiltBit = 2;

endpackage

// File: rtl/padring_io_ctrl_if.sv
// Core/padring bundle for the pad conditioning stage.
// master: drives core outputs, attributes, threshold and raw pad input.
interface padring_io_ctrl_if #(
  parameter int NPads    = padctrl_reg_pkg::NMioPads
                         + padctrl_reg_pkg::NDioPads,
  parameter int AttrDw   = padctrl_reg_pkg::AttrDw,
  parameter int FiltCntW = 4
);

  logic [NPads-1:0]        out_i;
  logic [NPads-1:0]        oe_i;
  logic [NPads*AttrDw-1:0] attr_i;
  logic [FiltCntW-1:0]     filt_thresh_i;
  logic [NPads-1:0]        pad_out_o;
  logic [NPads-1:0]        pad_oe_o;
  logic [NPads-1:0]        pad_in_i;
  logic [NPads-1:0]        in_o;
  logic [NPads-1:0]        in_rise_o;
  logic [NPads-1:0]        in_fall_o;

  modport master (
    output out_i, oe_i, attr_i,
    output filt_thresh_i, pad_in_i,
    input  pad_out_o, pad_oe_o,
    input  in_o, in_rise_o, in_fall_o
  );

  modport slave (
    input  out_i, oe_i, attr_i,
    input  filt_thresh_i, pad_in_i,
    output pad_out_o, pad_oe_o,
    output in_o, in_rise_o, in_fall_o
  );

endinterface

// File: rtl/padring_in_filter.sv
// One pad's input synchroniser plus stable-value glitch filter.
// pad_i raw async in; filt_en_i/thresh_i filter control; f_o filtered state.
module padring_in_filter #(
  parameter int SyncStages = 2,
  parameter int FiltCntW   = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pad_i,
  input  logic                filt_en_i,
  input  logic [FiltCntW-1:0] thresh_i,
  output logic                f_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic [FiltCntW-1:0]   cnt_q, cnt_d;
  logic                  f_q, f_d;
  logic                  s, byp, mis, hit;

  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], pad_i};
    s      = sync_q[SyncStages-1];
    byp    = !filt_en_i;
    mis    = filt_en_i && (s != f_q);
    // cnt saturates at the threshold, so >= also
    // covers a threshold lowered mid-count
    hit    = mis && (cnt_q >= thresh_i);
    f_d    = f_q;
    cnt_d  = '0;
    unique case (1'b1)
      byp || hit: f_d = s;
      mis && !hit: cnt_d = cnt_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      f_q    <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      f_q    <= f_d;
    end
  end

  assign f_o = f_q;

endmodule

// File: rtl/padring_io_ctrl.sv
// Per-pad I/O conditioning: output attrs + drive regs, filtered input, edges.
// clk_i, rst_ni (sync, active-low); io carries all pad/core signals.
module padring_io_ctrl #(
  parameter int NPads      = padctrl_reg_pkg::NMioPads
                           + padctrl_reg_pkg::NDioPads,
  parameter int AttrDw     = padctrl_reg_pkg::AttrDw,
  parameter int SyncStages = 2,
  parameter int FiltCntW   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  padring_io_ctrl_if.slave         io
);

  import padctrl_reg_pkg::*;

  logic [NPads-1:0] inv, od, fen, f;
  logic [NPads-1:0] v, in_o;
  logic [NPads-1:0] pad_out_q, pad_out_d;
  logic [NPads-1:0] pad_oe_q, pad_oe_d;
  logic [NPads-1:0] in_q, in_d;

  for (genvar p = 0; p < NPads; p++) begin : g_pad
    localparam int Base = p * AttrDw;
    logic unused_rsvd;

    assign inv[p] = io.attr_i[Base + AttrInvBit];
    assign od[p]  = io.attr_i[Base + AttrOdBit];
    assign fen[p] = io.attr_i[Base + AttrFiltBit];
    assign unused_rsvd =
      ^io.attr_i[Base + 3 +: AttrDw - 3];

    padring_in_filter #(
      .SyncStages(SyncStages),
      .FiltCntW  (FiltCntW)
    ) u_filt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .pad_i    (io.pad_in_i[p]),
      .filt_en_i(fen[p]),
      .thresh_i (io.filt_thresh_i),
      .f_o      (f[p])
    );
  end

  always_comb begin
    v         = io.out_i ^ inv;
    // open-drain never drives high: release instead
    pad_out_d = v & ~od;
    pad_oe_d  = io.oe_i & ~(od & v);
    in_o      = f ^ inv;
    in_d      = in_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pad_out_q <= '0;
      pad_oe_q  <= '0;
      in_q      <= '0;
    end else begin
      pad_out_q <= pad_out_d;
      pad_oe_q  <= pad_oe_d;
      in_q      <= in_d;
    end
  end

  assign io.pad_out_o = pad_out_q;
  assign io.pad_oe_o  = pad_oe_q;
  assign io.in_o      = in_o;
  assign io.in_rise_o = in_o & ~in_q;
  assign io.in_fall_o = ~in_o & in_q;

endmodule
